// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: RV32I opcodes (inst[6:2]),
// sequencer states and EX operand forwarding-select values.
package pipe_hazard_ctrl_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_RI     = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_RR     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_ECALL  = 5'b11100;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Youngest writer wins; a load that forced a stall is picked up from MEM.
  function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit,
                                          input logic mem_stalled_load);
    if (ex_hit) begin
      return FWD_MEM;
    end else if (mem_hit) begin
      return mem_stalled_load ? FWD_MEM : FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_fwd_unit.sv
// Combinational ID-stage hazard logic: source-use decode, forwarding compare
// against the EX/MEM writers, and load-use detection.
module hazard_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_wb_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              mem_wb_en,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              after_ld_stall,
  output logic [1:0]        rs1_sel,
  output logic [1:0]        rs2_sel,
  output logic              load_use
);

  localparam logic [REG_AW-1:0] X0 = {REG_AW{1'b0}};

  logic rs1_used_s, rs2_used_s;
  logic ex_writer_s, mem_writer_s;
  logic ex_hit1_s, ex_hit2_s, mem_hit1_s, mem_hit2_s;
  logic mem_stalled_ld_s;

  // Which source fields the ID opcode actually reads.
  always_comb begin
    rs1_used_s = 1'b0;
    rs2_used_s = 1'b0;
    case (id_opcode)
      OP_RR, OP_STORE, OP_BRANCH: begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b1;
      end
      OP_RI, OP_LOAD, OP_JALR: begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
      end
      OP_JAL, OP_LUI, OP_AUIPC, OP_ECALL: begin
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
      end
      default: begin
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
      end
    endcase
  end

  assign ex_writer_s  = ex_valid & ex_wb_en & (ex_rd != X0);
  assign mem_writer_s = mem_valid & mem_wb_en & (mem_rd != X0);

  assign ex_hit1_s  = id_valid & rs1_used_s & ex_writer_s & (ex_rd == id_rs1);
  assign ex_hit2_s  = id_valid & rs2_used_s & ex_writer_s & (ex_rd == id_rs2);
  assign mem_hit1_s = id_valid & rs1_used_s & mem_writer_s & (mem_rd == id_rs1);
  assign mem_hit2_s = id_valid & rs2_used_s & mem_writer_s & (mem_rd == id_rs2);

  assign mem_stalled_ld_s = after_ld_stall & mem_is_load;

  assign rs1_sel  = fwd_pick(ex_hit1_s, mem_hit1_s, mem_stalled_ld_s);
  assign rs2_sel  = fwd_pick(ex_hit2_s, mem_hit2_s, mem_stalled_ld_s);
  assign load_use = ex_is_load & (ex_hit1_s | ex_hit2_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: scoreboard, stall/flush/freeze,
// registered forwarding selects and ECALL drain-then-halt. Optional: PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 3
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wb_en,
  input  logic              ex_branch_taken,
  input  logic              dm_busy,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic              halt
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [REG_AW-1:0]  RD_ZERO    = {REG_AW{1'b0}};

  // The WB stage is not tracked: the regfile is write-through, so it never forwards.
  logic              ex_valid_r, ex_wb_en_r, ex_is_load_r;
  logic [REG_AW-1:0] ex_rd_r;
  logic              mem_valid_r, mem_wb_en_r, mem_is_load_r;
  logic [REG_AW-1:0] mem_rd_r;
  logic              ld_stall_r;
  logic [1:0]        fwd1_r, fwd2_r;
  state_t            state_r;
  logic [DRAIN_W-1:0] drain_cnt_r;
  logic              halt_r;

  logic [1:0] fwd1_s, fwd2_s;
  logic       load_use_s;
  logic       hold_s, flush_s, bubble_s, stall_s, ecall_go_s;

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .ex_valid       (ex_valid_r),
    .ex_wb_en       (ex_wb_en_r),
    .ex_is_load     (ex_is_load_r),
    .ex_rd          (ex_rd_r),
    .mem_valid      (mem_valid_r),
    .mem_wb_en      (mem_wb_en_r),
    .mem_is_load    (mem_is_load_r),
    .mem_rd         (mem_rd_r),
    .after_ld_stall (ld_stall_r),
    .rs1_sel        (fwd1_s),
    .rs2_sel        (fwd2_s),
    .load_use       (load_use_s)
  );

  // Pipeline control priority: freeze, then drain/halt, then branch, then load-use.
  always_comb begin
    hold_s     = 1'b0;
    flush_s    = 1'b0;
    bubble_s   = 1'b0;
    stall_s    = 1'b0;
    ecall_go_s = 1'b0;
    if (dm_busy) begin
      hold_s = 1'b1;
    end else if (state_r != ST_RUN) begin
      hold_s   = 1'b1;
      bubble_s = 1'b1;
    end else if (ex_branch_taken) begin
      flush_s  = 1'b1;
      bubble_s = 1'b1;
    end else if (load_use_s) begin
      hold_s   = 1'b1;
      bubble_s = 1'b1;
      stall_s  = 1'b1;
    end else begin
      ecall_go_s = id_valid & (id_opcode == OP_ECALL);
    end
  end

  // Scoreboard shift and forwarding-select capture on every unfrozen cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r    <= 1'b0;
      ex_wb_en_r    <= 1'b0;
      ex_is_load_r  <= 1'b0;
      ex_rd_r       <= RD_ZERO;
      mem_valid_r   <= 1'b0;
      mem_wb_en_r   <= 1'b0;
      mem_is_load_r <= 1'b0;
      mem_rd_r      <= RD_ZERO;
      ld_stall_r    <= 1'b0;
      fwd1_r        <= FWD_RF;
      fwd2_r        <= FWD_RF;
    end else if (!dm_busy) begin
      mem_valid_r   <= ex_valid_r;
      mem_wb_en_r   <= ex_wb_en_r;
      mem_is_load_r <= ex_is_load_r;
      mem_rd_r      <= ex_rd_r;
      ld_stall_r    <= stall_s;
      if (bubble_s || !id_valid) begin
        ex_valid_r   <= 1'b0;
        ex_wb_en_r   <= 1'b0;
        ex_is_load_r <= 1'b0;
        ex_rd_r      <= RD_ZERO;
        fwd1_r       <= FWD_RF;
        fwd2_r       <= FWD_RF;
      end else begin
        ex_valid_r   <= 1'b1;
        ex_wb_en_r   <= id_wb_en;
        ex_is_load_r <= (id_opcode == OP_LOAD);
        ex_rd_r      <= id_rd;
        fwd1_r       <= fwd1_s;
        fwd2_r       <= fwd2_s;
      end
    end
  end

  // ECALL sequencer: drain the older instructions, then halt until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= {DRAIN_W{1'b0}};
      halt_r      <= 1'b0;
    end else if (!dm_busy) begin
      case (state_r)
        ST_RUN: begin
          if (ecall_go_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= {DRAIN_W{1'b0}};
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r <= ST_HALT;
            halt_r  <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
          end
        end
        ST_HALT: begin
          halt_r <= 1'b1;
        end
        default: begin
          state_r <= ST_RUN;
          halt_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pc_hold     = hold_s;
  assign ifid_hold   = hold_s;
  assign ifid_flush  = flush_s;
  assign idex_bubble = bubble_s;
  assign pipe_freeze = dm_busy;
  assign fwd_rs1_sel = fwd1_r;
  assign fwd_rs2_sel = fwd2_r;
  assign halt        = halt_r;

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Event counters: freeze or load-use stall cycles, and branch flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (dm_busy || stall_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (flush_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic against a queue-based reference model of the in-flight instructions.
module tb_pipe_hazard_ctrl;

  localparam logic [4:0] T_LOAD   = 5'b00000;
  localparam logic [4:0] T_RI     = 5'b00100;
  localparam logic [4:0] T_AUIPC  = 5'b00101;
  localparam logic [4:0] T_STORE  = 5'b01000;
  localparam logic [4:0] T_RR     = 5'b01100;
  localparam logic [4:0] T_LUI    = 5'b01101;
  localparam logic [4:0] T_BRANCH = 5'b11000;
  localparam logic [4:0] T_JALR   = 5'b11001;
  localparam logic [4:0] T_JAL    = 5'b11011;
  localparam logic [4:0] T_ECALL  = 5'b11100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_opcode = 5'd0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic       id_wb_en = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       dm_busy = 1'b0;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, halt;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] ops [9] = '{T_LOAD, T_RI, T_AUIPC, T_STORE, T_RR, T_LUI, T_BRANCH, T_JALR, T_JAL};

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_wb_en(id_wb_en),
    .ex_branch_taken(ex_branch_taken), .dm_busy(dm_busy),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .halt(halt)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    bit wr;
    int rd;
    bit ld;
  } slot_t;

  slot_t      hist[$];      // instructions that entered EX, oldest first; last two kept
  bit         m_after_stall;
  logic [1:0] m_sel1, m_sel2;
  bit         e_hold, e_flush, e_bubble, e_lu;

  function automatic bit writes_rd(logic [4:0] op);
    return op inside {T_RR, T_RI, T_LOAD, T_JAL, T_JALR, T_LUI, T_AUIPC};
  endfunction
  function automatic bit reads_rs1(logic [4:0] op);
    return op inside {T_RR, T_RI, T_LOAD, T_STORE, T_BRANCH, T_JALR};
  endfunction
  function automatic bit reads_rs2(logic [4:0] op);
    return op inside {T_RR, T_STORE, T_BRANCH};
  endfunction
  function automatic bit wrote(slot_t s, logic [4:0] src);
    return s.v && s.wr && (s.rd != 0) && (s.rd == int'(src));
  endfunction
  function automatic logic [1:0] src_sel(bit used, logic [4:0] src);
    if (!used) return 2'd0;
    if (wrote(hist[1], src)) return 2'd1;
    if (wrote(hist[0], src)) return (m_after_stall && hist[0].ld) ? 2'd1 : 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    slot_t empty;
    empty.v = 0; empty.wr = 0; empty.rd = 0; empty.ld = 0;
    hist.delete();
    hist.push_back(empty);
    hist.push_back(empty);
    m_after_stall = 0;
    m_sel1 = 2'd0;
    m_sel2 = 2'd0;
  endtask

  task automatic model_predict();
    e_lu = id_valid && hist[1].ld &&
           ((reads_rs1(id_opcode) && wrote(hist[1], id_rs1)) ||
            (reads_rs2(id_opcode) && wrote(hist[1], id_rs2)));
    e_hold = 0; e_flush = 0; e_bubble = 0;
    if (dm_busy) e_hold = 1;
    else if (ex_branch_taken) begin e_flush = 1; e_bubble = 1; end
    else if (e_lu) begin e_hold = 1; e_bubble = 1; end
  endtask

  task automatic model_advance();
    slot_t s;
    if (!dm_busy) begin
      if (e_bubble || !id_valid) begin
        s.v = 0; s.wr = 0; s.rd = 0; s.ld = 0;
        m_sel1 = 2'd0; m_sel2 = 2'd0;
      end else begin
        s.v = 1; s.wr = id_wb_en; s.rd = int'(id_rd); s.ld = (id_opcode == T_LOAD);
        m_sel1 = src_sel(reads_rs1(id_opcode), id_rs1);
        m_sel2 = src_sel(reads_rs2(id_opcode), id_rs2);
      end
      hist.push_back(s);
      void'(hist.pop_front());
      m_after_stall = e_hold && e_bubble;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input logic br, input logic busy);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_wb_en = writes_rd(op); ex_branch_taken = br; dm_busy = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, T_RI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b0, T_RI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #7;
    n_checks++;
    if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, fwd_rs1_sel, fwd_rs2_sel, halt} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0", {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, fwd_rs1_sel, fwd_rs2_sel, halt});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, T_LOAD, 5'd2, 5'd0, 5'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, T_RR, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({pc_hold, ifid_hold, ifid_flush, idex_bubble} !== 4'b1101) begin
      n_fail++; $display("FAIL lu_stall: got %b want 1101", {pc_hold, ifid_hold, ifid_flush, idex_bubble});
    end
    tick();
    #1;
    n_checks++;
    if ({pc_hold, ifid_hold, idex_bubble} !== 3'b000) begin
      n_fail++; $display("FAIL lu_single_cycle: got %b want 000", {pc_hold, ifid_hold, idex_bubble});
    end
    tick();
    n_checks++;
    if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0100) begin
      n_fail++; $display("FAIL lu_fwd: got rs1=%0d rs2=%0d want 1/0", fwd_rs1_sel, fwd_rs2_sel);
    end
  endtask

  task automatic test_fwd_chain();
    do_reset();
    drive(1'b1, T_RR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, T_RR, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL chain_sub_nostall: got %b want 0", pc_hold); end
    tick();
    n_checks++;
    if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0101) begin
      n_fail++; $display("FAIL chain_sub_fwd: got %0d/%0d want 1/1", fwd_rs1_sel, fwd_rs2_sel);
    end
    drive(1'b1, T_RR, 5'd3, 5'd4, 5'd7, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL chain_or_nostall: got %b want 0", pc_hold); end
    tick();
    n_checks++;
    if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b1001) begin
      n_fail++; $display("FAIL chain_or_fwd: got %0d/%0d want 2/1", fwd_rs1_sel, fwd_rs2_sel);
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1'b1, T_RI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, T_RR, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL x0_nostall: got %b want 0", pc_hold); end
    tick();
    n_checks++;
    if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0000) begin
      n_fail++; $display("FAIL x0_fwd: got %0d/%0d want 0/0", fwd_rs1_sel, fwd_rs2_sel);
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    drive(1'b1, T_LOAD, 5'd2, 5'd0, 5'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, T_RR, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    #1;
    n_checks++;
    if ({pc_hold, ifid_hold, ifid_flush, idex_bubble} !== 4'b0011) begin
      n_fail++; $display("FAIL br_flush: got %b want 0011", {pc_hold, ifid_hold, ifid_flush, idex_bubble});
    end
    tick();
    n_checks++;
    if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0000) begin
      n_fail++; $display("FAIL br_bubble_sel: got %0d/%0d want 0/0", fwd_rs1_sel, fwd_rs2_sel);
    end
    drive(1'b1, T_RR, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({pc_hold, idex_bubble} !== 2'b00) begin
      n_fail++; $display("FAIL br_ex_empty: got %b want 00", {pc_hold, idex_bubble});
    end
    tick();
    n_checks++;
    if (fwd_rs1_sel !== 2'd2) begin n_fail++; $display("FAIL br_after_fwd: got %0d want 2", fwd_rs1_sel); end
  endtask

  task automatic test_freeze_stall();
    do_reset();
    drive(1'b1, T_LOAD, 5'd2, 5'd0, 5'd5, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, T_RR, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1);
      #1;
      n_checks++;
      if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze} !== 5'b11001) begin
        n_fail++; $display("FAIL frz_ctrl[%0d]: got %b want 11001", i, {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze});
      end
      tick();
      n_checks++;
      if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0000) begin
        n_fail++; $display("FAIL frz_sel_hold[%0d]: got %0d/%0d want 0/0", i, fwd_rs1_sel, fwd_rs2_sel);
      end
    end
    drive(1'b1, T_RR, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze} !== 5'b11010) begin
      n_fail++; $display("FAIL frz_stall_resume: got %b want 11010", {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze});
    end
    tick();
    tick();
    n_checks++;
    if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0100) begin
      n_fail++; $display("FAIL frz_fwd: got %0d/%0d want 1/0", fwd_rs1_sel, fwd_rs2_sel);
    end
`ifdef PERF_CNT_EN
    n_checks++;
    if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_stall_cnt: got %0d want 5", stall_cnt); end
`endif
  endtask

  task automatic test_ecall_halt();
    do_reset();
    drive(1'b1, T_RR, 5'd1, 5'd2, 5'd1, 1'b0, 1'b0); tick();
    drive(1'b1, T_RR, 5'd3, 5'd4, 5'd2, 1'b0, 1'b0); tick();
    drive(1'b1, T_RI, 5'd1, 5'd0, 5'd3, 1'b0, 1'b0); tick();
    drive(1'b1, T_ECALL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL ecall_enter: got %b want 0", pc_hold); end
    tick();
    drive(1'b0, T_RI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({pc_hold, ifid_hold, idex_bubble, halt} !== 4'b1110) begin
      n_fail++; $display("FAIL drain_ctrl: got %b want 1110", {pc_hold, ifid_hold, idex_bubble, halt});
    end
    tick();
    drive(1'b0, T_RI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    tick();
    drive(1'b0, T_RI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (halt !== 1'b0) begin n_fail++; $display("FAIL drain_not_done: got %b want 0", halt); end
    tick();
    n_checks++;
    if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b want 1", halt); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, T_RR, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0);
      #1;
      n_checks++;
      if ({halt, pc_hold, ifid_hold, ifid_flush, idex_bubble} !== 5'b11101) begin
        n_fail++; $display("FAIL halt_sticky[%0d]: got %b want 11101", i, {halt, pc_hold, ifid_hold, ifid_flush, idex_bubble});
      end
      tick();
    end
    drive(1'b1, T_RR, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({halt, pc_hold, ifid_hold, idex_bubble} !== 4'b0000) begin
      n_fail++; $display("FAIL halt_async_reset: got %b want 0000", {halt, pc_hold, ifid_hold, idex_bubble});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({halt, pc_hold} !== 2'b00) begin
      n_fail++; $display("FAIL run_after_reset: got %b want 00", {halt, pc_hold});
    end
  endtask

  task automatic test_random();
    logic       v, br, busy, hold_prev;
    logic [4:0] op, r1, r2, rd;
    do_reset();
    model_reset();
    hold_prev = 1'b0;
    v = 1'b0; op = T_RI; r1 = 5'd0; r2 = 5'd0; rd = 5'd0;
    for (int c = 0; c < 500; c++) begin
      if (!hold_prev) begin
        v  = ($urandom_range(9) != 0);
        op = ops[$urandom_range(8)];
        r1 = 5'($urandom_range(7));
        r2 = 5'($urandom_range(7));
        rd = 5'($urandom_range(7));
      end
      br   = ($urandom_range(9) == 0);
      busy = ($urandom_range(9) == 0);
      drive(v, op, r1, r2, rd, br, busy);
      model_predict();
      #1;
      n_checks++;
      if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze} !== {e_hold, e_hold, e_flush, e_bubble, busy}) begin
        n_fail++;
        $display("FAIL rnd_ctrl cycle %0d: got %b want %b", c, {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze},
                 {e_hold, e_hold, e_flush, e_bubble, busy});
      end
      hold_prev = e_hold;
      model_advance();
      tick();
      n_checks++;
      if ({fwd_rs1_sel, fwd_rs2_sel, halt} !== {m_sel1, m_sel2, 1'b0}) begin
        n_fail++;
        $display("FAIL rnd_fwd cycle %0d: got %0d/%0d halt %b want %0d/%0d halt 0", c, fwd_rs1_sel, fwd_rs2_sel, halt, m_sel1, m_sel2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_fwd_chain();
    test_x0();
    test_branch_flush();
    test_freeze_stall();
    test_random();
    test_ecall_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
